// File: rtl/onchip_ram_fill_engine.sv
// onchip_ram_fill_engine
//
// Avalon-MM master that sits in front of the on-chip RAM. It fills a
// region of the RAM with a constant or incrementing pattern, or reads the
// region back and compares it against that pattern. The Nios processor
// controls it through a small CSR slave, so it can clear RAM after reset
// and run a memory self-test without issuing its own loads and stores.
//
// Ports
//   clk, reset                 system clock, synchronous active-high reset
//   csr_address/chipselect/    CSR slave: 3-bit word select, strobes,
//   write/read/writedata/      32-bit write data, and registered read
//   readdata                   data valid the cycle after csr_read
//   irq                        level completion interrupt (done & IE)
//   ram_address/byteenable/    RAM master: word address, byte enables
//   chipselect/write/          (always 4'hF), access strobe, write
//   writedata/clken            qualifier, fill data, clock enable (always 1)
//   ram_readdata               RAM read data, valid one cycle after address
//
// DEPTH must equal 2**ADDR_W. Address wrap then comes from truncating the
// ADDR_W-bit sum.

module onchip_ram_fill_engine #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        csr_address,
    input  logic              csr_chipselect,
    input  logic              csr_write,
    input  logic              csr_read,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic              irq,
    output logic [ADDR_W-1:0] ram_address,
    output logic [3:0]        ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    // The length and index need one bit more than an address so they can
    // hold a full-RAM count of DEPTH.
    localparam int LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_VERIFY = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]  errcnt_q, errcnt_d;
    logic [ADDR_W-1:0] failaddr_q, failaddr_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              aborted_q, aborted_d;
    logic              mode_q, mode_d;
    logic              incr_q, incr_d;
    logic              ie_q, ie_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic              irq_q, irq_d;
    logic [31:0]       csr_readdata_q, csr_readdata_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic              ram_chipselect_q, ram_chipselect_d;
    logic              ram_write_q, ram_write_d;
    logic [DATA_W-1:0] ram_writedata_q, ram_writedata_d;
    // Compare stage: the read issued last cycle, its address and expected word
    logic              cmp_valid_q, cmp_valid_d;
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
    logic [DATA_W-1:0] cmp_exp_q, cmp_exp_d;

    logic              busy_s;
    logic              reg_wr_s;
    logic              ctrl_wr_s;
    logic              start_s;
    logic              abort_s;
    logic              clr_s;
    logic              done_set_s;
    logic              mismatch_s;
    logic [ADDR_W-1:0] issue_addr_s;
    logic [DATA_W-1:0] issue_data_s;
    logic [31:0]       rd_mux_s;

    assign csr_readdata   = csr_readdata_q;
    assign irq            = irq_q;
    assign ram_address    = ram_address_q;
    assign ram_byteenable = 4'hF;
    assign ram_chipselect = ram_chipselect_q;
    assign ram_write      = ram_write_q;
    assign ram_writedata  = ram_writedata_q;
    assign ram_clken      = 1'b1;

    // Next-state logic: CSR decode, FSM sequencing, compare and status flags
    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        len_d            = len_q;
        pattern_d        = pattern_q;
        errcnt_d         = errcnt_q;
        failaddr_d       = failaddr_q;
        mode_d           = mode_q;
        incr_d           = incr_q;
        ie_d             = ie_q;
        idx_d            = idx_q;
        ram_address_d    = ram_address_q;
        ram_writedata_d  = ram_writedata_q;
        ram_chipselect_d = 1'b0;
        ram_write_d      = 1'b0;
        cmp_addr_d       = ram_address_q;
        cmp_exp_d        = ram_writedata_q;
        done_set_s       = 1'b0;
        rd_mux_s         = 32'h0000_0000;

        busy_s    = (state_q != S_IDLE);
        reg_wr_s  = csr_chipselect & csr_write;
        ctrl_wr_s = reg_wr_s & (csr_address == 3'd0);
        // ABORT in the same write suppresses START
        start_s   = ctrl_wr_s & csr_writedata[0] & ~csr_writedata[4] & ~busy_s;
        abort_s   = ctrl_wr_s & csr_writedata[4] & busy_s;
        clr_s     = ctrl_wr_s & csr_writedata[5];

        issue_addr_s = base_q + idx_q[ADDR_W-1:0];
        if (incr_q) begin
            issue_data_s = pattern_q + DATA_W'(idx_q);
        end else begin
            issue_data_s = pattern_q;
        end

        // Configuration registers are frozen while an operation runs
        if (ctrl_wr_s) begin
            ie_d = csr_writedata[3];
            if (!busy_s) begin
                mode_d = csr_writedata[1];
                incr_d = csr_writedata[2];
            end else begin
                mode_d = mode_q;
                incr_d = incr_q;
            end
        end else begin
            ie_d = ie_q;
        end

        if (reg_wr_s && !busy_s) begin
            case (csr_address)
                3'd1: base_d = csr_writedata[ADDR_W-1:0];
                3'd2: begin
                    if (csr_writedata > 32'(DEPTH)) begin
                        len_d = LEN_W'(DEPTH);
                    end else begin
                        len_d = csr_writedata[LEN_W-1:0];
                    end
                end
                3'd3: pattern_d = csr_writedata[DATA_W-1:0];
                default: base_d = base_q;
            endcase
        end else begin
            base_d = base_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    idx_d = LEN_W'(1);
                    if (len_q == '0) begin
                        done_set_s = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        // Issue index 0 straight away so it appears at N+1
                        state_d          = csr_writedata[1] ? S_VERIFY : S_FILL;
                        ram_chipselect_d = 1'b1;
                        ram_write_d      = ~csr_writedata[1];
                        ram_address_d    = base_q;
                        ram_writedata_d  = pattern_q;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL, S_VERIFY: begin
                if (abort_s) begin
                    state_d    = S_IDLE;
                    done_set_s = 1'b1;
                end else if (idx_q == len_q) begin
                    // Writes finish at once; reads still owe one compare
                    if (state_q == S_FILL) begin
                        state_d    = S_IDLE;
                        done_set_s = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    ram_chipselect_d = 1'b1;
                    ram_write_d      = (state_q == S_FILL);
                    ram_address_d    = issue_addr_s;
                    ram_writedata_d  = issue_data_s;
                    idx_d            = idx_q + LEN_W'(1);
                end
            end
            S_DRAIN: begin
                state_d    = S_IDLE;
                done_set_s = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The read visible on the bus now returns data next cycle; an abort
        // throws away both that pending compare and the one happening now.
        cmp_valid_d = ram_chipselect_q & ~ram_write_q & ~abort_s;
        mismatch_s  = cmp_valid_q & ~abort_s & (ram_readdata != cmp_exp_q);

        if (start_s) begin
            errcnt_d   = '0;
            failaddr_d = '0;
        end else if (mismatch_s) begin
            if (errcnt_q != {LEN_W{1'b1}}) begin
                errcnt_d = errcnt_q + LEN_W'(1);
            end else begin
                errcnt_d = errcnt_q;
            end
            // errcnt is still zero only for the first mismatch since START
            if (errcnt_q == '0) begin
                failaddr_d = cmp_addr_q;
            end else begin
                failaddr_d = failaddr_q;
            end
        end else begin
            errcnt_d   = errcnt_q;
            failaddr_d = failaddr_q;
        end

        // Setting beats clearing, so a completion coinciding with CLR_DONE
        // leaves done asserted.
        if (done_set_s) begin
            done_d = 1'b1;
        end else if (start_s || clr_s) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end

        if (mismatch_s) begin
            error_d = 1'b1;
        end else if (start_s || clr_s) begin
            error_d = 1'b0;
        end else begin
            error_d = error_q;
        end

        if (abort_s) begin
            aborted_d = 1'b1;
        end else if (start_s || clr_s) begin
            aborted_d = 1'b0;
        end else begin
            aborted_d = aborted_q;
        end

        irq_d = done_d & ie_d;

        case (csr_address)
            3'd0: rd_mux_s = {21'h0, ie_q, incr_q, mode_q, 4'h0,
                              aborted_q, error_q, done_q, busy_s};
            3'd1: rd_mux_s = 32'(base_q);
            3'd2: rd_mux_s = 32'(len_q);
            3'd3: rd_mux_s = 32'(pattern_q);
            3'd4: rd_mux_s = 32'(errcnt_q);
            3'd5: rd_mux_s = 32'(failaddr_q);
            default: rd_mux_s = 32'h0000_0000;
        endcase

        if (csr_chipselect && csr_read) begin
            csr_readdata_d = rd_mux_s;
        end else begin
            csr_readdata_d = csr_readdata_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            base_q           <= '0;
            len_q            <= '0;
            pattern_q        <= '0;
            errcnt_q         <= '0;
            failaddr_q       <= '0;
            done_q           <= 1'b0;
            error_q          <= 1'b0;
            aborted_q        <= 1'b0;
            mode_q           <= 1'b0;
            incr_q           <= 1'b0;
            ie_q             <= 1'b0;
            idx_q            <= '0;
            irq_q            <= 1'b0;
            csr_readdata_q   <= 32'h0000_0000;
            ram_address_q    <= '0;
            ram_chipselect_q <= 1'b0;
            ram_write_q      <= 1'b0;
            ram_writedata_q  <= '0;
            cmp_valid_q      <= 1'b0;
            cmp_addr_q       <= '0;
            cmp_exp_q        <= '0;
        end else begin
            state_q          <= state_d;
            base_q           <= base_d;
            len_q            <= len_d;
            pattern_q        <= pattern_d;
            errcnt_q         <= errcnt_d;
            failaddr_q       <= failaddr_d;
            done_q           <= done_d;
            error_q          <= error_d;
            aborted_q        <= aborted_d;
            mode_q           <= mode_d;
            incr_q           <= incr_d;
            ie_q             <= ie_d;
            idx_q            <= idx_d;
            irq_q            <= irq_d;
            csr_readdata_q   <= csr_readdata_d;
            ram_address_q    <= ram_address_d;
            ram_chipselect_q <= ram_chipselect_d;
            ram_write_q      <= ram_write_d;
            ram_writedata_q  <= ram_writedata_d;
            cmp_valid_q      <= cmp_valid_d;
            cmp_addr_q       <= cmp_addr_d;
            cmp_exp_q        <= cmp_exp_d;
        end
    end

endmodule

// File: tb/tb_onchip_ram_fill_engine.sv
// Directed testbench for onchip_ram_fill_engine with a behavioural
// on-chip RAM (one-cycle read latency). Inputs are driven and outputs
// sampled on the falling clock edge.

module tb_onchip_ram_fill_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  csr_address;
    logic        csr_chipselect;
    logic        csr_write;
    logic        csr_read;
    logic [31:0] csr_writedata;
    logic [31:0] csr_readdata;
    logic        irq;
    logic [11:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic        ram_clken;
    logic [31:0] ram_readdata;

    int checks   = 0;
    int failures = 0;

    // RAM model state and bus activity counters
    logic [31:0] mem [0:4095];
    int          wr_cnt = 0;
    int          cs_cnt = 0;
    logic        poke_en = 1'b0;
    logic [11:0] poke_addr = 12'h000;
    logic [31:0] poke_data = 32'h0;

    onchip_ram_fill_engine dut (
        .clk            (clk),
        .reset          (reset),
        .csr_address    (csr_address),
        .csr_chipselect (csr_chipselect),
        .csr_write      (csr_write),
        .csr_read       (csr_read),
        .csr_writedata  (csr_writedata),
        .csr_readdata   (csr_readdata),
        .irq            (irq),
        .ram_address    (ram_address),
        .ram_byteenable (ram_byteenable),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_clken      (ram_clken),
        .ram_readdata   (ram_readdata)
    );

    always #5 clk = ~clk;

    // On-chip RAM: registered read, write on strobe, plus a bench poke port
    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        if (ram_chipselect) cs_cnt <= cs_cnt + 1;
        if (ram_chipselect && ram_write) begin
            mem[ram_address] <= ram_writedata;
            wr_cnt <= wr_cnt + 1;
        end
        if (ram_chipselect && !ram_write) ram_readdata <= mem[ram_address];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // All tasks start at a falling edge and return at a later falling edge
    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        csr_address = a; csr_writedata = d; csr_chipselect = 1'b1; csr_write = 1'b1;
        @(negedge clk);
        csr_chipselect = 1'b0; csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
        csr_address = a; csr_chipselect = 1'b1; csr_read = 1'b1;
        @(negedge clk);
        csr_chipselect = 1'b0; csr_read = 1'b0;
        d = csr_readdata;
    endtask

    task automatic mem_poke(input logic [11:0] a, input logic [31:0] d);
        poke_addr = a; poke_data = d; poke_en = 1'b1;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic wait_irq(input int max_cycles);
        int n = 0;
        while (irq !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check_eq("irq_wait", {31'h0, irq}, 32'h1);
    endtask

    task automatic run_tests();
        logic [31:0] rd;
        int          snap;
        logic [11:0] wrap_addr [4];
        wrap_addr[0] = 12'hFFE; wrap_addr[1] = 12'hFFF;
        wrap_addr[2] = 12'h000; wrap_addr[3] = 12'h001;

        // Reset state
        check_eq("rst_cs", {31'h0, ram_chipselect}, 32'h0);
        check_eq("rst_we", {31'h0, ram_write}, 32'h0);
        check_eq("rst_addr", {20'h0, ram_address}, 32'h0);
        check_eq("rst_wdata", ram_writedata, 32'h0);
        check_eq("rst_irq", {31'h0, irq}, 32'h0);
        check_eq("rst_rdata", csr_readdata, 32'h0);
        check_eq("be", {28'h0, ram_byteenable}, 32'hF);
        check_eq("clken", {31'h0, ram_clken}, 32'h1);
        csr_rd(3'd0, rd); check_eq("rst_status", rd, 32'h0);

        // Constant fill with interrupt enabled
        csr_wr(3'd1, 32'h010);
        csr_wr(3'd2, 32'd4);
        csr_wr(3'd3, 32'hDEADBEEF);
        csr_wr(3'd0, 32'h9);
        for (int i = 0; i < 4; i++) begin
            check_eq("cf_cs", {30'h0, ram_chipselect, ram_write}, 32'h3);
            check_eq("cf_addr", {20'h0, ram_address}, 32'h010 + i);
            check_eq("cf_data", ram_writedata, 32'hDEADBEEF);
            check_eq("cf_irq_busy", {31'h0, irq}, 32'h0);
            @(negedge clk);
        end
        check_eq("cf_cs_end", {31'h0, ram_chipselect}, 32'h0);
        check_eq("cf_irq", {31'h0, irq}, 32'h1);
        csr_rd(3'd0, rd); check_eq("cf_status", rd, 32'h402);
        check_eq("cf_mem", mem[12'h012], 32'hDEADBEEF);

        // CLR_DONE (also clears IE)
        csr_wr(3'd0, 32'h20);
        check_eq("clr_irq", {31'h0, irq}, 32'h0);
        csr_rd(3'd0, rd); check_eq("clr_status", rd, 32'h0);

        // Incrementing fill across the address wrap
        csr_wr(3'd1, 32'hFFE);
        csr_wr(3'd3, 32'h100);
        csr_wr(3'd0, 32'h5);
        for (int i = 0; i < 4; i++) begin
            check_eq("wf_cs", {30'h0, ram_chipselect, ram_write}, 32'h3);
            check_eq("wf_addr", {20'h0, ram_address}, {20'h0, wrap_addr[i]});
            check_eq("wf_data", ram_writedata, 32'h100 + i);
            @(negedge clk);
        end
        check_eq("wf_cs_end", {31'h0, ram_chipselect}, 32'h0);
        csr_rd(3'd0, rd); check_eq("wf_status", rd, 32'h202);
        check_eq("wf_mem0", mem[12'h000], 32'h102);

        // Verify with word 0x000 corrupted; done (irq) at N+6
        mem_poke(12'h000, 32'h0);
        csr_wr(3'd0, 32'hF);
        check_eq("vf_cs1", {30'h0, ram_chipselect, ram_write}, 32'h2);
        check_eq("vf_addr1", {20'h0, ram_address}, 32'hFFE);
        repeat (3) @(negedge clk);
        check_eq("vf_addr4", {20'h0, ram_address}, 32'h001);
        check_eq("vf_cs4", {30'h0, ram_chipselect, ram_write}, 32'h2);
        @(negedge clk);
        check_eq("vf_cs5", {31'h0, ram_chipselect}, 32'h0);
        check_eq("vf_irq5", {31'h0, irq}, 32'h0);
        @(negedge clk);
        check_eq("vf_irq6", {31'h0, irq}, 32'h1);
        csr_rd(3'd4, rd); check_eq("vf_errcnt", rd, 32'h1);
        csr_rd(3'd5, rd); check_eq("vf_failaddr", rd, 32'h000);
        csr_rd(3'd0, rd); check_eq("vf_status", rd, 32'h706);

        // LEN=0: done next cycle, no RAM access
        csr_wr(3'd2, 32'd0);
        snap = cs_cnt;
        csr_wr(3'd0, 32'h9);
        check_eq("l0_irq", {31'h0, irq}, 32'h1);
        check_eq("l0_cs", {31'h0, ram_chipselect}, 32'h0);
        csr_rd(3'd0, rd); check_eq("l0_status", rd, 32'h402);
        check_eq("l0_cs_cnt", cs_cnt - snap, 32'h0);

        // LEN clamp and full-RAM fill
        csr_wr(3'd1, 32'h000);
        csr_wr(3'd3, 32'hA5A5A5A5);
        csr_wr(3'd2, 32'h1FFF);
        csr_rd(3'd2, rd); check_eq("len_clamp", rd, 32'd4096);
        snap = wr_cnt;
        csr_wr(3'd0, 32'h9);
        check_eq("full_irq_start", {31'h0, irq}, 32'h0);
        wait_irq(5000);
        check_eq("full_writes", wr_cnt - snap, 32'd4096);
        check_eq("full_mem_last", mem[12'hFFF], 32'hA5A5A5A5);

        // Abort a 100-word fill at cycle N+10
        csr_wr(3'd2, 32'd100);
        snap = wr_cnt;
        csr_wr(3'd0, 32'h9);
        repeat (9) @(negedge clk);
        check_eq("ab_cs_before", {31'h0, ram_chipselect}, 32'h1);
        csr_wr(3'd0, 32'h18);
        check_eq("ab_cs_after", {31'h0, ram_chipselect}, 32'h0);
        check_eq("ab_writes", wr_cnt - snap, 32'd10);
        check_eq("ab_irq", {31'h0, irq}, 32'h1);
        csr_rd(3'd0, rd); check_eq("ab_status", rd, 32'h40A);

        // START and ABORT together: nothing starts
        snap = cs_cnt;
        csr_wr(3'd0, 32'h11);
        check_eq("sa_cs", {31'h0, ram_chipselect}, 32'h0);
        csr_rd(3'd0, rd); check_eq("sa_busy", rd & 32'h1, 32'h0);
        check_eq("sa_cs_cnt", cs_cnt - snap, 32'h0);

        // Reset in the middle of a verify
        csr_wr(3'd2, 32'd20);
        csr_wr(3'd0, 32'hB);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("rm_cs", {31'h0, ram_chipselect}, 32'h0);
        check_eq("rm_irq", {31'h0, irq}, 32'h0);
        snap = cs_cnt;
        repeat (4) @(negedge clk);
        check_eq("rm_cs_cnt", cs_cnt - snap, 32'h0);
        csr_rd(3'd0, rd); check_eq("rm_status", rd, 32'h0);
        csr_rd(3'd2, rd); check_eq("rm_len", rd, 32'h0);

        // Normal operation after the reset
        csr_wr(3'd1, 32'h100);
        csr_wr(3'd2, 32'd2);
        csr_wr(3'd3, 32'h55);
        csr_wr(3'd0, 32'h1);
        check_eq("pr_a0", {20'h0, ram_address}, 32'h100);
        check_eq("pr_cs0", {30'h0, ram_chipselect, ram_write}, 32'h3);
        check_eq("pr_d0", ram_writedata, 32'h55);
        @(negedge clk);
        check_eq("pr_a1", {20'h0, ram_address}, 32'h101);
        check_eq("pr_d1", ram_writedata, 32'h55);
        @(negedge clk);
        check_eq("pr_cs_end", {31'h0, ram_chipselect}, 32'h0);
        csr_rd(3'd0, rd); check_eq("pr_status", rd, 32'h2);
    endtask

    initial begin
        reset = 1'b1;
        csr_address = 3'd0; csr_chipselect = 1'b0; csr_write = 1'b0;
        csr_read = 1'b0; csr_writedata = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        run_tests();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/onchip_ram_fill_engine.md
Name: onchip_ram_fill_engine

Overview:
- Avalon-MM master sitting directly upstream of the on-chip RAM slave: 12-bit word address, 32-bit data, byteenable, clken, read data valid one cycle after address.
- A CSR slave lets the Nios processor command block fills (constant or incrementing pattern) and read-back verification of any region.
- Used for post-reset RAM clearing and memory self-test without CPU load/store traffic.

Parameters:
- ADDR_W, 12, RAM word-address width.
- DATA_W, 32, RAM data width.
- DEPTH, 4096, RAM depth in words; address arithmetic wraps modulo DEPTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- csr_address  in  3  CSR word select.
- csr_chipselect  in  1  CSR select.
- csr_write  in  1  CSR write strobe.
- csr_read  in  1  CSR read strobe.
- csr_writedata  in  32  CSR write data.
- csr_readdata  out  32  CSR read data, registered, valid the cycle after csr_read.
- irq  out  1  completion interrupt, level.
- ram_address  out  ADDR_W  RAM word address.
- ram_byteenable  out  4  constant 4'hF.
- ram_chipselect  out  1  RAM access strobe.
- ram_write  out  1  RAM write; 0 with chipselect=1 means read.
- ram_writedata  out  DATA_W  fill data.
- ram_clken  out  1  constant 1.
- ram_readdata  in  DATA_W  RAM read data, valid the cycle after the address.

Behaviour:
- CSR map; writes take effect on any cycle where csr_chipselect & csr_write:
  - 0 CTRL (W): b0 START, b1 MODE (0 fill, 1 verify), b2 INCR, b3 IE, b4 ABORT, b5 CLR_DONE.
  - 0 STATUS (R): b0 busy, b1 done, b2 error, b3 aborted, b8 MODE, b9 INCR, b10 IE.
  - 1 BASE: 12 bits.
  - 2 LEN: 13 bits, values above 4096 clamp to 4096.
  - 3 PATTERN: 32 bits.
  - 4 ERRCNT: 13 bits, read-only.
  - 5 FAILADDR: 12 bits, first miscompare address, read-only.
  - 6-7 read 0.
- Writes to BASE, LEN and PATTERN are ignored while busy. START while busy is ignored.
- Reset values: all registers 0, FSM IDLE, csr_readdata=0, irq=0, ram_chipselect=0, ram_write=0, ram_address=0, ram_writedata=0.
- FSM states: IDLE, FILL, VERIFY, DRAIN.
- START accepted in cycle N:
  - idx := 0; ERRCNT, FAILADDR, done, error and aborted are cleared; busy=1 from N+1.
  - LEN=0: no RAM access; done=1 at N+1, busy drops at N+1.
- Addressing and data for each idx:
  - ram_address = (BASE + idx) mod DEPTH; wraps 4095 -> 0.
  - expected/fill value = PATTERN + idx (mod 2^32) if INCR, else PATTERN.
- FILL:
  - One write per cycle, cycles N+1..N+LEN, with chipselect=1 and write=1.
  - After the last write: IDLE, done=1 at N+LEN+1.
- VERIFY:
  - One read per cycle, cycles N+1..N+LEN, with chipselect=1 and write=0.
  - The address and expected value are pipelined one stage; ram_readdata is compared in the following cycle.
  - After the last issue, enter DRAIN for one compare cycle; done=1 at N+LEN+2.
  - On mismatch: ERRCNT saturating +1, error=1; FAILADDR is written only on the first mismatch.
- ABORT while busy:
  - The next cycle deasserts ram_chipselect; any in-flight verify compare is discarded.
  - busy=0, aborted=1, done=1.
  - ABORT in IDLE has no effect.
- START and ABORT in the same write: ABORT wins; no operation starts.
- CLR_DONE clears done, error and aborted. If it coincides with internal completion, completion wins and done=1.
- irq = done & IE, registered.
- ram_* outputs are registered. Outside active access cycles: chipselect=0 and write=0.
- Reset asserted mid-operation: next cycle all state returns to reset values; no further RAM strobes.

Test Plan:
- Fill, constant: BASE=0x010, LEN=4, PATTERN=0xDEADBEEF, INCR=0, START -> writes to 0x010..0x013 on 4 consecutive cycles, all data 0xDEADBEEF; done=1 one cycle after the last write; irq=1 if IE.
- Fill with wrap: BASE=0xFFE, LEN=4, PATTERN=0x100, INCR=1 -> addresses FFE, FFF, 000, 001 with data 0x100, 0x101, 0x102, 0x103.
- Verify, mismatch: RAM model preloaded with 0x100..0x103 at 0xFFE..0x001, with word 0x000 corrupted to 0 -> ERRCNT=1, FAILADDR=0x000, error=1, done at N+6.
- Edge cases: LEN=0 START -> done the next cycle, ram_chipselect never asserted. LEN written 0x1FFF -> reads back 4096, and a full fill issues exactly 4096 writes.
- Abort: start a fill with LEN=100, write ABORT at cycle 10 -> chipselect drops the next cycle, aborted=1, done=1. START+ABORT in one write -> busy stays 0.
- Reset mid-verify: assert reset at cycle 5 -> the next cycle STATUS=0, irq=0, no RAM strobes; a subsequent START operates normally.
